// File: rtl/rot_pkg.sv
// Shared definitions for the rotator arbiter slice.
// Provides the FSM state encoding and datapath widths.
package rot_pkg;

    // Rotator word width and rotate-amount width.
    localparam int ROT_W = 4;
    localparam int AMT_W = 2;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : rot_pkg

// File: rtl/barrel_8.sv
// Two-stage mux rotator: rotates a 4-bit word right by {s1,s0}.
// Ports: w (word in), s1/s0 (amount bits), y (rotated word out).
module barrel_8 (
    input  logic [3:0] w,
    input  logic       s1,
    input  logic       s0,
    output logic [3:0] y
);

    logic [3:0] stage1;

    // Stage 1 rotates right by one, stage 2 rotates right by two.
    assign stage1 = s0 ? {w[0], w[3:1]} : w;
    assign y      = s1 ? {stage1[1:0], stage1[3:2]} : stage1;

endmodule : barrel_8

// File: rtl/rot_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one barrel_8 rotator.
// Ports: clk, rst_n (sync, active-low); req_valid/req_data/req_amt in,
// req_ready one-hot out; res_valid/res_data/res_id out, res_ready in;
// busy out (1 whenever the sequencer is not idle).
module rot_arb_ctrl
    import rot_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [ROT_W*NREQ-1:0] req_data,
    input  logic [AMT_W*NREQ-1:0] req_amt,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [ROT_W-1:0]      res_data,
    output logic [ID_W-1:0]       res_id,
    input  logic                  res_ready,
    output logic                  busy
);

    state_t           state;
    logic [ID_W-1:0]  last;
    logic [ROT_W-1:0] data_q;
    logic [AMT_W-1:0] amt_q;
    logic [ID_W-1:0]  id_q;

    logic [ID_W-1:0]  grant;
    logic             any_valid;
    logic             accept;
    logic [ROT_W-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;
    logic [ROT_W-1:0] rot_out;

    // Round-robin pick: lowest valid index above 'prev' if any,
    // otherwise the lowest valid index overall (wrap-around).
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NREQ-1:0] v,
        input logic [ID_W-1:0] prev
    );
        logic            has_hi;
        logic [ID_W-1:0] pick_hi;
        logic [ID_W-1:0] pick_lo;
        has_hi  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        // Descending scan so the last write is the lowest match.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                pick_lo = ID_W'(i);
                if (i > int'(prev)) begin
                    has_hi  = 1'b1;
                    pick_hi = ID_W'(i);
                end
            end
        end
        return has_hi ? pick_hi : pick_lo;
    endfunction

    assign any_valid = |req_valid;
    assign grant     = rr_pick(req_valid, last);
    assign accept    = rst_n && (state == IDLE) && any_valid;

    // One-hot ready strobe and operand mux for the granted requester.
    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_amt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_data     = req_data[ROT_W*i +: ROT_W];
                sel_amt      = req_amt[AMT_W*i +: AMT_W];
            end
        end
    end

    barrel_8 u_rot (
        .w  (data_q),
        .s1 (amt_q[1]),
        .s0 (amt_q[0]),
        .y  (rot_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= ID_W'(NREQ - 1);
            data_q    <= '0;
            amt_q     <= '0;
            id_q      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        data_q <= sel_data;
                        amt_q  <= sel_amt;
                        id_q   <= grant;
                        last   <= grant;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= rot_out;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : rot_arb_ctrl

// File: tb/tb_rot_arb_ctrl.sv
// Directed self-checking bench for rot_arb_ctrl.
// Drives requester vectors and checks handshake, ordering and data.
module tb_rot_arb_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [7:0]  req_amt;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [3:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        busy;

    int passes = 0;
    int total  = 0;

    rot_arb_ctrl #(.NREQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Independent rotate-right reference.
    function automatic logic [3:0] rotr(input logic [3:0] w,
                                        input int a);
        logic [7:0] d;
        d = {w, w} >> a;
        return d[3:0];
    endfunction

    // One full transaction from IDLE with res_ready held high.
    task automatic txn(input string tag, input logic [3:0] exp_rdy,
                       input logic [3:0] exp_data, input logic [1:0] exp_id);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        tick();
        check({tag, "_exec_busy"}, 32'(busy), 32'd1);
        check({tag, "_exec_rv"}, 32'(res_valid), 32'd0);
        check({tag, "_exec_rdy"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, "_rv"}, 32'(res_valid), 32'd1);
        check({tag, "_data"}, 32'(res_data), 32'(exp_data));
        check({tag, "_id"}, 32'(res_id), 32'(exp_id));
        tick();
        check({tag, "_done_rv"}, 32'(res_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 16'h0;
        req_amt   = 8'h0;
        res_ready = 1'b0;

        // Reset state, ready held low even with requests pending.
        tick();
        tick();
        check("rst_rv", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_rdy", 32'(req_ready), 32'd0);
        rst_n     = 1'b1;
        req_valid = 4'h0;
        #1;
        check("idle_rdy", 32'(req_ready), 32'd0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // 1: single request, 1000 rotated right by 1.
        req_valid = 4'b0001;
        req_data  = 16'h0008;
        req_amt   = 8'h01;
        res_ready = 1'b1;
        txn("t1", 4'b0001, 4'b0100, 2'd0);
        req_valid = 4'h0;

        // 2: all valid, amt_i = i, grants in order 0..3.
        do_reset();
        req_valid = 4'hF;
        req_data  = 16'h1111;
        req_amt   = 8'b11_10_01_00;
        txn("t2g0", 4'b0001, 4'b0001, 2'd0);
        txn("t2g1", 4'b0010, 4'b1000, 2'd1);
        txn("t2g2", 4'b0100, 4'b0100, 2'd2);
        txn("t2g3", 4'b1000, 4'b0010, 2'd3);

        // 3: backpressure in RESP for 5 cycles (next grant is 0).
        res_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t3_rv", 32'(res_valid), 32'd1);
            check("t3_data", 32'(res_data), 32'b0001);
            check("t3_id", 32'(res_id), 32'd0);
            check("t3_rdy", 32'(req_ready), 32'd0);
            check("t3_busy", 32'(busy), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("t3_rel_rv", 32'(res_valid), 32'd0);
        req_valid = 4'h0;
        res_ready = 1'b1;
        tick();
        check("t3_idle_ready_nop", 32'(res_valid), 32'd0);

        // 4: wrap from requester 3 back to 0, then to 3.
        do_reset();
        req_data  = 16'h1234;
        req_amt   = 8'h00;
        req_valid = 4'b1000;
        txn("t4a", 4'b1000, 4'h1, 2'd3);
        req_valid = 4'b1001;
        txn("t4b", 4'b0001, 4'h4, 2'd0);
        txn("t4c", 4'b1000, 4'h1, 2'd3);

        // 5: reset while in RESP drops the result, pointer returns to 0.
        req_valid = 4'b0010;
        res_ready = 1'b0;
        tick();
        req_valid = 4'h0;
        tick();
        check("t5_pre_rv", 32'(res_valid), 32'd1);
        check("t5_pre_id", 32'(res_id), 32'd1);
        do_reset();
        check("t5_rv", 32'(res_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        res_ready = 1'b1;
        req_valid = 4'hF;
        txn("t5g", 4'b0001, 4'h4, 2'd0);

        // 6: sweep all words and amounts from requester 2.
        do_reset();
        req_valid = 4'b0100;
        for (int w = 0; w < 16; w++) begin
            for (int a = 0; a < 4; a++) begin
                req_data = {4'hA, 4'(w), 4'h5, 4'hC};
                req_amt  = {2'd3, 2'(a), 2'd1, 2'd2};
                txn("t6", 4'b0100, rotr(4'(w), a), 2'd2);
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish");
        $fatal(1, "timeout");
    end

endmodule : tb_rot_arb_ctrl
